// File: rtl/pb_pkg.sv
// ============================================================================
// Module  : pb_pkg
// Brief   : Shared defaults and filter state encoding for pb_debounce.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pb_pkg;

    localparam int PB_WIDTH           = 5;
    localparam int PB_CNT_W           = 16;
    localparam int PB_DEBOUNCE_CYCLES = 50000;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } pb_state_t;

endpackage

`default_nettype wire

// File: rtl/pb_debounce_if.sv
// ============================================================================
// Module  : pb_debounce_if
// Brief   : Button bus between board pins/CPU port and pb_debounce.
//           Sticky signals exist only when PB_DEBOUNCE_STICKY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pb_debounce_if #(
    parameter int WIDTH = pb_pkg::PB_WIDTH
);
    logic [WIDTH-1:0] pb_raw;
    logic [WIDTH-1:0] pb_level;
    logic [WIDTH-1:0] pb_press;
    logic [WIDTH-1:0] pb_release;
`ifdef PB_DEBOUNCE_STICKY_EN
    logic [WIDTH-1:0] sticky_clr;
    logic [WIDTH-1:0] pb_sticky;

    modport master (output pb_raw, output sticky_clr,
                    input  pb_level, input pb_press, input pb_release, input pb_sticky);
    modport slave  (input  pb_raw, input  sticky_clr,
                    output pb_level, output pb_press, output pb_release, output pb_sticky);
`else
    modport master (output pb_raw,
                    input  pb_level, input pb_press, input pb_release);
    modport slave  (input  pb_raw,
                    output pb_level, output pb_press, output pb_release);
`endif
endinterface

`default_nettype wire

// File: rtl/pb_debounce_ch.sv
// ============================================================================
// Module  : pb_debounce_ch
// Brief   : One button channel: 2-flop synchronizer, stability counter,
//           debounced level, press/release pulses, optional sticky flag
//           (PB_DEBOUNCE_STICKY_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_debounce_ch
    import pb_pkg::*;
#(
    parameter int CNT_W           = PB_CNT_W,
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_pb_raw,
`ifdef PB_DEBOUNCE_STICKY_EN
    input  wire logic i_sticky_clr,
    output logic      o_sticky,
`endif
    output logic      o_level,
    output logic      o_press,
    output logic      o_release
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_cnt;
    pb_state_t        r_state;

    logic w_mismatch;
    logic w_done;

    assign w_mismatch = (r_sync2 != r_level);
    // Counter is 0 in IDLE, so w_done there only holds for DEBOUNCE_CYCLES == 1.
    assign w_done     = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
        end else begin
            r_sync1   <= i_pb_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_mismatch) begin
                        if (w_done) begin
                            r_level   <= r_sync2;
                            r_press   <= r_sync2;
                            r_release <= ~r_sync2;
                        end else begin
                            r_cnt   <= CNT_W'(1);
                            r_state <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    if (!w_mismatch) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_done) begin
                        r_level   <= r_sync2;
                        r_press   <= r_sync2;
                        r_release <= ~r_sync2;
                        r_cnt     <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef PB_DEBOUNCE_STICKY_EN
    logic r_sticky;
    logic w_set;

    // Same condition that raises r_press; set dominates clear so no press is lost.
    assign w_set = w_mismatch && w_done && r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_set) begin
            r_sticky <= 1'b1;
        end else if (i_sticky_clr) begin
            r_sticky <= 1'b0;
        end
    end

    assign o_sticky = r_sticky;
`endif

endmodule

`default_nettype wire

// File: rtl/pb_debounce.sv
// ============================================================================
// Module  : pb_debounce
// Brief   : WIDTH independent push-button debounce channels.
//           Optional sticky press latch: PB_DEBOUNCE_STICKY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_debounce
    import pb_pkg::*;
#(
    parameter int WIDTH           = PB_WIDTH,
    parameter int CNT_W           = PB_CNT_W,
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES
) (
    input  wire logic     clk,
    input  wire logic     rst,
    pb_debounce_if.slave  pb
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            pb_debounce_ch #(
                .CNT_W           (CNT_W),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .i_pb_raw     (pb.pb_raw[i]),
`ifdef PB_DEBOUNCE_STICKY_EN
                .i_sticky_clr (pb.sticky_clr[i]),
                .o_sticky     (pb.pb_sticky[i]),
`endif
                .o_level      (pb.pb_level[i]),
                .o_press      (pb.pb_press[i]),
                .o_release    (pb.pb_release[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pb_debounce.sv
// ============================================================================
// Module  : tb_pb_debounce
// Brief   : Scoreboard bench for pb_debounce, DEBOUNCE_CYCLES=4, WIDTH=5.
//           Sticky scenario is built only with PB_DEBOUNCE_STICKY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pb_debounce;

    localparam int W = 5;
    localparam int D = 4;
    // Output index (0 = first edge after the input change) where level flips.
    localparam int L = D + 1;

    typedef struct packed {
        logic [W-1:0] level;
        logic [W-1:0] press;
        logic [W-1:0] rel;
        logic [W-1:0] sticky;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pb_debounce_if #(.WIDTH(W)) bus ();

    pb_debounce #(
        .WIDTH           (W),
        .CNT_W           (16),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pb  (bus)
    );

    task automatic tick(input logic [W-1:0] raw, input logic [W-1:0] clr);
        bus.pb_raw = raw;
`ifdef PB_DEBOUNCE_STICKY_EN
        bus.sticky_clr = clr;
`else
        if (clr != '0) $display("note: sticky_clr ignored in this build");
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            sb.push_back('{level: '0, press: '0, rel: '0, sticky: '0});
            tick(5'h1F, '0);
            e = sb.pop_front();
            n_tests++;
            if (bus.pb_level !== e.level || bus.pb_press !== e.press || bus.pb_release !== e.rel) begin
                n_fail++;
                $display("FAIL reset_hold j=%0d got lvl=%h prs=%h rel=%h want lvl=%h prs=%h rel=%h",
                         j, bus.pb_level, bus.pb_press, bus.pb_release, e.level, e.press, e.rel);
            end
        end
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            sb.push_back('{level: (j >= L) ? 5'h1F : 5'h00, press: (j == L) ? 5'h1F : 5'h00,
                           rel: '0, sticky: '0});
            tick(5'h1F, '0);
            e = sb.pop_front();
            n_tests++;
            if (bus.pb_level !== e.level || bus.pb_press !== e.press || bus.pb_release !== e.rel) begin
                n_fail++;
                $display("FAIL reset_held_press j=%0d got lvl=%h prs=%h rel=%h want lvl=%h prs=%h rel=%h",
                         j, bus.pb_level, bus.pb_press, bus.pb_release, e.level, e.press, e.rel);
            end
        end
        // Second reset with buttons released returns everything to 0.
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            sb.push_back('{level: '0, press: '0, rel: '0, sticky: '0});
            tick(5'h00, '0);
            e = sb.pop_front();
            n_tests++;
            if (bus.pb_level !== e.level || bus.pb_press !== e.press || bus.pb_release !== e.rel) begin
                n_fail++;
                $display("FAIL reset_clear j=%0d got lvl=%h prs=%h rel=%h want lvl=%h prs=%h rel=%h",
                         j, bus.pb_level, bus.pb_press, bus.pb_release, e.level, e.press, e.rel);
            end
`ifdef PB_DEBOUNCE_STICKY_EN
            n_tests++;
            if (bus.pb_sticky !== e.sticky) begin
                n_fail++;
                $display("FAIL reset_sticky j=%0d got %h want %h", j, bus.pb_sticky, e.sticky);
            end
`endif
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        for (int j = 0; j < 8; j++) begin
            sb.push_back('{level: (j >= L) ? 5'h01 : 5'h00, press: (j == L) ? 5'h01 : 5'h00,
                           rel: '0, sticky: '0});
            tick(5'h01, '0);
            e = sb.pop_front();
            n_tests++;
            if (bus.pb_level !== e.level || bus.pb_press !== e.press || bus.pb_release !== e.rel) begin
                n_fail++;
                $display("FAIL clean_press j=%0d got lvl=%h prs=%h rel=%h want lvl=%h prs=%h rel=%h",
                         j, bus.pb_level, bus.pb_press, bus.pb_release, e.level, e.press, e.rel);
            end
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] raw;
        // ch2 toggles 1,0,1,0 then settles high from index 4.
        for (int j = 0; j < 12; j++) begin
            raw = (j < 4 && (j % 2) == 1) ? 5'h01 : 5'h05;
            sb.push_back('{level: (j >= 4 + L) ? 5'h05 : 5'h01, press: (j == 4 + L) ? 5'h04 : 5'h00,
                           rel: '0, sticky: '0});
            tick(raw, '0);
            e = sb.pop_front();
            n_tests++;
            if (bus.pb_level !== e.level || bus.pb_press !== e.press || bus.pb_release !== e.rel) begin
                n_fail++;
                $display("FAIL bounce j=%0d got lvl=%h prs=%h rel=%h want lvl=%h prs=%h rel=%h",
                         j, bus.pb_level, bus.pb_press, bus.pb_release, e.level, e.press, e.rel);
            end
        end
    endtask

    task automatic test_glitch_reject();
        for (int j = 0; j < 10; j++) begin
            sb.push_back('{level: 5'h05, press: '0, rel: '0, sticky: '0});
            tick((j < 3) ? 5'h0D : 5'h05, '0);
            e = sb.pop_front();
            n_tests++;
            if (bus.pb_level !== e.level || bus.pb_press !== e.press || bus.pb_release !== e.rel) begin
                n_fail++;
                $display("FAIL glitch j=%0d got lvl=%h prs=%h rel=%h want lvl=%h prs=%h rel=%h",
                         j, bus.pb_level, bus.pb_press, bus.pb_release, e.level, e.press, e.rel);
            end
        end
    endtask

    task automatic test_release_independence();
        for (int j = 0; j < 8; j++) begin
            sb.push_back('{level: (j >= L) ? 5'h17 : 5'h05, press: (j == L) ? 5'h12 : 5'h00,
                           rel: '0, sticky: '0});
            tick(5'h17, '0);
            e = sb.pop_front();
            n_tests++;
            if (bus.pb_level !== e.level || bus.pb_press !== e.press || bus.pb_release !== e.rel) begin
                n_fail++;
                $display("FAIL press_1_4 j=%0d got lvl=%h prs=%h rel=%h want lvl=%h prs=%h rel=%h",
                         j, bus.pb_level, bus.pb_press, bus.pb_release, e.level, e.press, e.rel);
            end
        end
        for (int j = 0; j < 8; j++) begin
            sb.push_back('{level: (j >= L) ? 5'h05 : 5'h17, press: '0,
                           rel: (j == L) ? 5'h12 : 5'h00, sticky: '0});
            tick(5'h05, '0);
            e = sb.pop_front();
            n_tests++;
            if (bus.pb_level !== e.level || bus.pb_press !== e.press || bus.pb_release !== e.rel) begin
                n_fail++;
                $display("FAIL release_1_4 j=%0d got lvl=%h prs=%h rel=%h want lvl=%h prs=%h rel=%h",
                         j, bus.pb_level, bus.pb_press, bus.pb_release, e.level, e.press, e.rel);
            end
        end
    endtask

`ifdef PB_DEBOUNCE_STICKY_EN
    task automatic test_sticky();
        // Channels 0,1,2,4 were pressed earlier; clear them all.
        sb.push_back('{level: 5'h05, press: '0, rel: '0, sticky: '0});
        tick(5'h05, 5'h1F);
        e = sb.pop_front();
        n_tests++;
        if (bus.pb_sticky !== e.sticky) begin
            n_fail++;
            $display("FAIL sticky_clear_all got %h want %h", bus.pb_sticky, e.sticky);
        end
        for (int j = 0; j < 8; j++) begin
            sb.push_back('{level: (j >= L) ? 5'h04 : 5'h05, press: '0,
                           rel: (j == L) ? 5'h01 : 5'h00, sticky: '0});
            tick(5'h04, '0);
            e = sb.pop_front();
            n_tests++;
            if (bus.pb_level !== e.level || bus.pb_release !== e.rel || bus.pb_sticky !== e.sticky) begin
                n_fail++;
                $display("FAIL sticky_release j=%0d got lvl=%h rel=%h stk=%h want lvl=%h rel=%h stk=%h",
                         j, bus.pb_level, bus.pb_release, bus.pb_sticky, e.level, e.rel, e.sticky);
            end
        end
        // Clear lands on the same edge as the press: set must win.
        for (int j = 0; j < 8; j++) begin
            sb.push_back('{level: (j >= L) ? 5'h05 : 5'h04, press: (j == L) ? 5'h01 : 5'h00,
                           rel: '0, sticky: (j >= L) ? 5'h01 : 5'h00});
            tick(5'h05, (j == L) ? 5'h01 : 5'h00);
            e = sb.pop_front();
            n_tests++;
            if (bus.pb_level !== e.level || bus.pb_press !== e.press || bus.pb_sticky !== e.sticky) begin
                n_fail++;
                $display("FAIL sticky_set_wins j=%0d got lvl=%h prs=%h stk=%h want lvl=%h prs=%h stk=%h",
                         j, bus.pb_level, bus.pb_press, bus.pb_sticky, e.level, e.press, e.sticky);
            end
        end
        for (int j = 0; j < 2; j++) begin
            sb.push_back('{level: 5'h05, press: '0, rel: '0, sticky: '0});
            tick(5'h05, 5'h01);
            e = sb.pop_front();
            n_tests++;
            if (bus.pb_sticky !== e.sticky || bus.pb_level !== e.level) begin
                n_fail++;
                $display("FAIL sticky_clear j=%0d got stk=%h lvl=%h want stk=%h lvl=%h",
                         j, bus.pb_sticky, bus.pb_level, e.sticky, e.level);
            end
        end
    endtask
`endif

    initial begin
        bus.pb_raw = '0;
`ifdef PB_DEBOUNCE_STICKY_EN
        bus.sticky_clr = '0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch_reject();
        test_release_independence();
`ifdef PB_DEBOUNCE_STICKY_EN
        test_sticky();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pb_debounce.md
# pb_debounce

Push-button conditioning stage between the board's raw button pins and the CPU's memory-mapped push-button port. Synchronizes each asynchronous button input, filters contact bounce with a per-channel counter, and produces clean levels plus one-cycle press/release pulses. With the optional sticky latch, software cannot miss a short press between polls.

## Interface
- `WIDTH`, 5, number of button channels
- `CNT_W`, 16, debounce counter width
- `DEBOUNCE_CYCLES`, 50000, consecutive stable cycles required to accept a change; legal range 1 .. 2^CNT_W−1
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `pb_raw`  in  WIDTH  raw button pins, asynchronous, 1 = pressed
- `pb_level`  out  WIDTH  debounced button state; feeds the CPU push-button port
- `pb_press`  out  WIDTH  one-cycle pulse on each accepted 0→1 change
- `pb_release`  out  WIDTH  one-cycle pulse on each accepted 1→0 change
- `sticky_clr`  in  WIDTH  per-bit clear of `pb_sticky`; present only with `PB_DEBOUNCE_STICKY_EN`
- `pb_sticky`  out  WIDTH  latched press flags; present only with `PB_DEBOUNCE_STICKY_EN`

## Operation
- Each channel is independent and identical.
- Synchronizer: two flops, `sync1 <= pb_raw[i]`, `sync2 <= sync1`. Only `sync2` is used downstream.
- Per-channel filter, two states:
  - IDLE: `sync2 == level`, counter held at 0.
  - COUNT: `sync2 != level`.
- On each edge with a mismatch:
  - If counter == DEBOUNCE_CYCLES−1: flip `level`, clear the counter, and assert `pb_press` (new level 1) or `pb_release` (new level 0) on the same edge.
  - Otherwise increment the counter.
- Any edge with `sync2 == level` clears the counter. A single-cycle glitch restarts the count.
- Counter never exceeds DEBOUNCE_CYCLES−1, so no wrap occurs. Comparison is unsigned at CNT_W bits.
- DEBOUNCE_CYCLES = 1: `level` follows `sync2` with one flop of delay.
- Pulses last exactly one cycle. Press and release for the same channel are never asserted together.
- Reset: sync flops, `level`, counters, `pb_press`, `pb_release` and `pb_sticky` all go to 0 (all buttons released). Reset during a count discards that count. A button held through reset registers as a press DEBOUNCE_CYCLES+2 cycles after reset deasserts.

## Timing
- Let `pb_raw[i]` change and stay stable before edge k (captured into `sync1` at k).
  - `sync2` updates at k+1.
  - `level` and the pulse update at edge k+1+DEBOUNCE_CYCLES.
- Input-to-level latency is DEBOUNCE_CYCLES+2 edges, counting edge k as the first.
- `pb_level` and the pulses are registered outputs with no combinational path from the inputs.
- Sticky: set on the same edge `pb_press[i]` asserts. Visible on `pb_sticky` from the following cycle.

## Configuration
- Macro: `PB_DEBOUNCE_STICKY_EN`.
- Defined:
  - `pb_sticky[i]` sets on `pb_press[i]` and clears on an edge with `sticky_clr[i]` = 1.
  - If set and clear occur on the same edge, set wins, so no press is lost.
  - A clear with no pending press leaves the flag at 0.
- Undefined:
  - `sticky_clr` and `pb_sticky` ports are absent and no sticky flops are built.
  - All other behaviour is identical.

## Structure
- Shared package `pb_pkg`: default `WIDTH`, default `CNT_W`, default `DEBOUNCE_CYCLES`, and the IDLE/COUNT state encoding.
- Sub-module `pb_debounce_ch`: one channel (synchronizer, counter, level, pulses, optional sticky flag), instantiated WIDTH times through a generate loop.
- Top-level `pb_debounce` contains only the generate loop and port wiring.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, WIDTH=5.
- Reset: hold `rst`=1 for 3 cycles with `pb_raw`=5'h1F. All outputs read 0. After `rst` drops, `pb_level`=5'h1F and `pb_press`=5'h1F for one cycle, exactly 6 edges later.
- Clean press: `pb_raw[0]` 0→1 and held. `pb_level[0]` rises on the 6th edge, with `pb_press[0]` high for that single cycle. `pb_release` stays 0.
- Bounce: `pb_raw[2]` toggles 1,0,1,0 on consecutive cycles, then stays 1. No pulses during the toggling. `pb_level[2]` rises 6 edges after the final 0→1 change.
- Glitch reject: `pb_raw[3]` pulses high for 3 cycles only. `pb_level[3]`, `pb_press[3]` and `pb_release[3]` stay 0 throughout.
- Release and independence: channels 1 and 4 are pressed (stable), then both released on the same cycle. `pb_release`=5'h12 for one cycle, 6 edges later. Other channels are unaffected.
- Sticky (macro defined): press channel 0, then assert `sticky_clr[0]`=1 on the same edge as a second `pb_press[0]`. `pb_sticky[0]` stays 1. A later clear with no press drives it to 0.
